regfile_write_arbiter: RTL and testbench

//  Shares the single regfile write port (ctrl_writeEnable/ctrl_writeReg/data_writeReg) between CPU writeback
//  and two game-side requesters (P0: shape-change/keyboard logic, P1: gravity/drop timer).
//  CPU has priority; each peripheral has a 1-deep holding buffer served round-robin in idle CPU cycles.
//  A starvation guard stalls the CPU for one slot when a peripheral write has waited MAX_WAIT cycles.

---
 rtl/regfile_write_arbiter.sv | 137 +++++++++++++
 tb/tb_regfile_write_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Shares the regfile write port between CPU writeback and two peripheral requesters.
// CPU has priority; peripherals are buffered one deep, served round-robin, and force a slot when starved.
module regfile_write_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int MAX_WAIT = 8,
  parameter int WCNT_W   = 4
) (
  input  logic              clock,
  input  logic              ctrl_reset,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_waddr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              p0_req,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_data,
  input  logic              p1_req,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_data,
  output logic              p0_ack,
  output logic              p1_ack,
  output logic              stall_cpu,
  output logic              ctrl_writeEnable,
  output logic [ADDR_W-1:0] ctrl_writeReg,
  output logic [DATA_W-1:0] data_writeReg
);

  localparam logic [WCNT_W-1:0] WCNT_MAX = '1;
  localparam logic [WCNT_W-1:0] WAIT_LIM = WCNT_W'(MAX_WAIT);

  logic [1:0]        req_vec;
  logic [1:0]        ack_vec;
  logic [1:0]        buf_vld;
  logic [1:0]        starve_vec;
  logic [1:0]        gnt_buf;
  logic              gnt_cpu;
  logic              cpu_vld;
  logic              rr_p1;
  logic [ADDR_W-1:0] req_addr [2];
  logic [DATA_W-1:0] req_data [2];
  logic [ADDR_W-1:0] buf_addr [2];
  logic [DATA_W-1:0] buf_data [2];
  logic [WCNT_W-1:0] wcnt     [2];

  logic              wr_vld_p0;
  logic [ADDR_W-1:0] wr_addr_p0;
  logic [DATA_W-1:0] wr_data_p0;

  // Stage p0: grant decision, capture handshake and write-port mux
  always_comb begin
    req_vec     = {p1_req, p0_req};
    req_addr[0] = p0_addr;
    req_addr[1] = p1_addr;
    req_data[0] = p0_data;
    req_data[1] = p1_data;
    cpu_vld     = cpu_we && (cpu_waddr != '0);

    for (int k = 0; k < 2; k++) begin
      starve_vec[k] = buf_vld[k] && (wcnt[k] >= WAIT_LIM);
    end

    gnt_buf = 2'b00;
    gnt_cpu = 1'b0;
    if (|starve_vec) begin
      gnt_buf = (&starve_vec) ? (rr_p1 ? 2'b10 : 2'b01) : starve_vec;
    end else if (cpu_vld) begin
      gnt_cpu = 1'b1;
    end else if (&buf_vld) begin
      gnt_buf = rr_p1 ? 2'b10 : 2'b01;
    end else begin
      gnt_buf = buf_vld;
    end

    stall_cpu = |starve_vec;

    // A buffer being drained this cycle can accept the next request at the same edge
    for (int k = 0; k < 2; k++) begin
      ack_vec[k] = req_vec[k] && (!buf_vld[k] || gnt_buf[k]);
    end
    p0_ack = ack_vec[0];
    p1_ack = ack_vec[1];

    wr_vld_p0  = gnt_cpu || (|gnt_buf);
    wr_addr_p0 = cpu_waddr;
    wr_data_p0 = cpu_wdata;
    if (gnt_buf[0]) begin
      wr_addr_p0 = buf_addr[0];
      wr_data_p0 = buf_data[0];
    end else if (gnt_buf[1]) begin
      wr_addr_p0 = buf_addr[1];
      wr_data_p0 = buf_data[1];
    end
  end

  // Stage p1: buffer state, wait counters, RR pointer and registered write port
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      buf_vld          <= 2'b00;
      wcnt[0]          <= '0;
      wcnt[1]          <= '0;
      rr_p1            <= 1'b0;
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg    <= '0;
      data_writeReg    <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        // Writes to r0 are acknowledged but never occupy the buffer
        if (ack_vec[k]) begin
          buf_vld[k] <= (req_addr[k] != '0);
        end else if (gnt_buf[k]) begin
          buf_vld[k] <= 1'b0;
        end
        if (buf_vld[k] && !gnt_buf[k]) begin
          wcnt[k] <= (wcnt[k] == WCNT_MAX) ? wcnt[k] : wcnt[k] + 1'b1;
        end else begin
          wcnt[k] <= '0;
        end
      end
      if (|gnt_buf) begin
        rr_p1 <= gnt_buf[0];
      end
      ctrl_writeEnable <= wr_vld_p0;
      ctrl_writeReg    <= wr_addr_p0;
      data_writeReg    <= wr_data_p0;
    end
  end

  always_ff @(posedge clock) begin
    for (int k = 0; k < 2; k++) begin
      if (ack_vec[k]) begin
        buf_addr[k] <= req_addr[k];
        buf_data[k] <= req_data[k];
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed vector table, starvation and reset sequences,
// then randomized traffic checked against a rule-level reference model.
module tb_regfile_write_arbiter;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int MAX_WAIT = 8;
  localparam int WCNT_W   = 4;
  localparam int AGE_MAX  = (1 << WCNT_W) - 1;

  logic              clock;
  logic              ctrl_reset;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_waddr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              preq  [2];
  logic [ADDR_W-1:0] paddr [2];
  logic [DATA_W-1:0] pdata [2];
  logic              p0_ack, p1_ack, stall_cpu, ctrl_writeEnable;
  logic [ADDR_W-1:0] ctrl_writeReg;
  logic [DATA_W-1:0] data_writeReg;

  regfile_write_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT), .WCNT_W(WCNT_W)
  ) dut (
    .clock(clock), .ctrl_reset(ctrl_reset),
    .cpu_we(cpu_we), .cpu_waddr(cpu_waddr), .cpu_wdata(cpu_wdata),
    .p0_req(preq[0]), .p0_addr(paddr[0]), .p0_data(pdata[0]),
    .p1_req(preq[1]), .p1_addr(paddr[1]), .p1_data(pdata[1]),
    .p0_ack(p0_ack), .p1_ack(p1_ack), .stall_cpu(stall_cpu),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic              cwe;
    logic [ADDR_W-1:0] ca;
    logic [DATA_W-1:0] cd;
    logic              r0;
    logic [ADDR_W-1:0] a0;
    logic [DATA_W-1:0] d0;
    logic              r1;
    logic [ADDR_W-1:0] a1;
    logic [DATA_W-1:0] d1;
    logic              e_ack0;
    logic              e_ack1;
    logic              e_stall;
    logic              e_we;
    logic [ADDR_W-1:0] e_reg;
    logic [DATA_W-1:0] e_data;
  } vec_t;

  function automatic vec_t mk(input logic cwe, input int ca, input int cd,
                              input logic r0, input int a0, input int d0,
                              input logic r1, input int a1, input int d1,
                              input logic ea0, input logic ea1, input logic est,
                              input logic ewe, input int ereg, input int edat);
    vec_t v;
    v.cwe = cwe; v.ca = ADDR_W'(ca); v.cd = DATA_W'(cd);
    v.r0 = r0; v.a0 = ADDR_W'(a0); v.d0 = DATA_W'(d0);
    v.r1 = r1; v.a1 = ADDR_W'(a1); v.d1 = DATA_W'(d1);
    v.e_ack0 = ea0; v.e_ack1 = ea1; v.e_stall = est;
    v.e_we = ewe; v.e_reg = ADDR_W'(ereg); v.e_data = DATA_W'(edat);
    return v;
  endfunction

  task automatic drive_idle();
    cpu_we = 1'b0; cpu_waddr = '0; cpu_wdata = '0;
    for (int k = 0; k < 2; k++) begin
      preq[k] = 1'b0; paddr[k] = '0; pdata[k] = '0;
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    drive_idle();
    ctrl_reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    ctrl_reset = 1'b0;
  endtask

  // Reference model: buffer contents with ages, plus identity of the last peripheral served
  bit                mv   [2];
  logic [ADDR_W-1:0] ma   [2];
  logic [DATA_W-1:0] md   [2];
  int                mage [2];
  int                last_pg;

  function automatic int pick_winner(input logic cwe, input logic [ADDR_W-1:0] ca);
    int nst = 0, st = -1, nv = 0, v = -1, pref;
    pref = (last_pg == 0) ? 1 : 0;
    for (int k = 0; k < 2; k++) begin
      if (mv[k] && mage[k] >= MAX_WAIT) begin nst++; st = k; end
      if (mv[k]) begin nv++; v = k; end
    end
    if (nst == 2) return pref;
    if (nst == 1) return st;
    if (cwe && ca != 0) return 2;
    if (nv == 2) return pref;
    return v;
  endfunction

  vec_t tbl [16];

  initial begin
    int stall_at;
    int g;
    logic eack [2];
    logic estall, exp_we;
    logic [ADDR_W-1:0] exp_reg;
    logic [DATA_W-1:0] exp_data;

    ctrl_reset = 1'b0;
    drive_idle();

    //          cwe ca  cd     r0 a0 d0      r1 a1 d1      ack0 ack1 stl  we reg data
    tbl[0]  = mk(0, 0,  0,     1, 2, 1,      0, 0, 0,      1, 0, 0,       0, 0, 0);
    tbl[1]  = mk(0, 0,  0,     0, 0, 0,      0, 0, 0,      0, 0, 0,       1, 2, 1);
    tbl[2]  = mk(0, 0,  0,     1, 4, 'h11,   1, 5, 'h22,   1, 1, 0,       0, 0, 0);
    tbl[3]  = mk(0, 0,  0,     0, 0, 0,      1, 6, 'h33,   0, 1, 0,       1, 5, 'h22);
    tbl[4]  = mk(0, 0,  0,     0, 0, 0,      0, 0, 0,      0, 0, 0,       1, 4, 'h11);
    tbl[5]  = mk(0, 0,  0,     0, 0, 0,      0, 0, 0,      0, 0, 0,       1, 6, 'h33);
    tbl[6]  = mk(1, 7,  'h77,  0, 0, 0,      1, 8, 'h88,   0, 1, 0,       1, 7, 'h77);
    tbl[7]  = mk(1, 9,  'h99,  0, 0, 0,      0, 0, 0,      0, 0, 0,       1, 9, 'h99);
    tbl[8]  = mk(1, 0,  'hAA,  0, 0, 0,      0, 0, 0,      0, 0, 0,       1, 8, 'h88);
    tbl[9]  = mk(0, 0,  0,     1, 0, 5,      0, 0, 0,      1, 0, 0,       0, 0, 0);
    tbl[10] = mk(0, 0,  0,     0, 0, 0,      0, 0, 0,      0, 0, 0,       0, 0, 0);
    tbl[11] = mk(1, 1,  1,     1, 10, 'hA,   0, 0, 0,      1, 0, 0,       1, 1, 1);
    tbl[12] = mk(1, 1,  2,     1, 11, 'hB,   0, 0, 0,      0, 0, 0,       1, 1, 2);
    tbl[13] = mk(0, 0,  0,     1, 11, 'hB,   0, 0, 0,      1, 0, 0,       1, 10, 'hA);
    tbl[14] = mk(0, 0,  0,     0, 0, 0,      0, 0, 0,      0, 0, 0,       1, 11, 'hB);
    tbl[15] = mk(0, 0,  0,     0, 0, 0,      0, 0, 0,      0, 0, 0,       0, 0, 0);

    // Reset state
    @(negedge clock);
    ctrl_reset = 1'b1;
    #1;
    chk("reset_we", ctrl_writeEnable, 0);
    chk("reset_reg", ctrl_writeReg, 0);
    chk("reset_data", data_writeReg, 0);
    chk("reset_stall", stall_cpu, 0);
    chk("reset_acks", {p0_ack, p1_ack}, 0);
    @(negedge clock);
    ctrl_reset = 1'b0;

    // Directed vector table
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      cpu_we = tbl[i].cwe; cpu_waddr = tbl[i].ca; cpu_wdata = tbl[i].cd;
      preq[0] = tbl[i].r0; paddr[0] = tbl[i].a0; pdata[0] = tbl[i].d0;
      preq[1] = tbl[i].r1; paddr[1] = tbl[i].a1; pdata[1] = tbl[i].d1;
      #2;
      chk($sformatf("tbl%0d_ack0", i), p0_ack, tbl[i].e_ack0);
      chk($sformatf("tbl%0d_ack1", i), p1_ack, tbl[i].e_ack1);
      chk($sformatf("tbl%0d_stall", i), stall_cpu, tbl[i].e_stall);
      @(posedge clock);
      #1;
      chk($sformatf("tbl%0d_we", i), ctrl_writeEnable, tbl[i].e_we);
      if (tbl[i].e_we) begin
        chk($sformatf("tbl%0d_reg", i), ctrl_writeReg, tbl[i].e_reg);
        chk($sformatf("tbl%0d_data", i), data_writeReg, tbl[i].e_data);
      end
    end

    // Starvation: CPU writes every cycle while P1 waits for r3
    do_reset();
    @(negedge clock);
    cpu_we = 1'b1; cpu_waddr = 5'd1; cpu_wdata = 32'h100;
    preq[1] = 1'b1; paddr[1] = 5'd3; pdata[1] = 32'h6;
    #2;
    chk("starve_ack1", p1_ack, 1);
    stall_at = -1;
    for (int i = 1; i <= 20 && stall_at < 0; i++) begin
      @(negedge clock);
      preq[1] = 1'b0;
      cpu_waddr = ADDR_W'(1 + (i % 30));
      cpu_wdata = 32'h100 + DATA_W'(i);
      #2;
      if (stall_cpu) stall_at = i;
    end
    chk("starve_cycle", stall_at, MAX_WAIT + 1);
    @(posedge clock);
    #1;
    chk("starve_issue", {ctrl_writeEnable, ctrl_writeReg, data_writeReg}, {1'b1, 5'd3, 32'h6});
    @(negedge clock);
    #2;
    chk("starve_release", stall_cpu, 0);
    @(posedge clock);
    #1;
    chk("starve_resume", {ctrl_writeEnable, ctrl_writeReg, data_writeReg},
        {1'b1, ADDR_W'(1 + (stall_at % 30)), 32'h100 + DATA_W'(stall_at)});

    // Reset mid-flight discards a buffered write
    do_reset();
    @(negedge clock);
    preq[0] = 1'b1; paddr[0] = 5'd12; pdata[0] = 32'hC;
    #2;
    chk("rstmid_ack", p0_ack, 1);
    @(negedge clock);
    preq[0] = 1'b0;
    ctrl_reset = 1'b1;
    #1;
    chk("rstmid_we", ctrl_writeEnable, 0);
    @(negedge clock);
    ctrl_reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      #1;
      chk($sformatf("rstmid_idle%0d", i), ctrl_writeEnable, 0);
    end

    // Randomized traffic against the reference model
    do_reset();
    for (int k = 0; k < 2; k++) begin mv[k] = 0; mage[k] = 0; ma[k] = '0; md[k] = '0; end
    last_pg = -1;
    eack[0] = 1'b0; eack[1] = 1'b0; estall = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clock);
      for (int k = 0; k < 2; k++) begin
        if (!(preq[k] && !eack[k])) begin
          preq[k]  = ($urandom % 3 == 0);
          paddr[k] = ADDR_W'($urandom % 32);
          pdata[k] = $urandom;
        end
      end
      if (!estall) begin
        cpu_we    = ($urandom % 8 != 0);
        cpu_waddr = ADDR_W'($urandom % 32);
        cpu_wdata = $urandom;
      end
      g = pick_winner(cpu_we, cpu_waddr);
      estall = 1'b0;
      for (int k = 0; k < 2; k++) begin
        eack[k] = preq[k] && (!mv[k] || g == k);
        if (mv[k] && mage[k] >= MAX_WAIT) estall = 1'b1;
      end
      #2;
      chk($sformatf("rnd%0d_ctl", cyc), {p0_ack, p1_ack, stall_cpu}, {eack[0], eack[1], estall});
      @(posedge clock);
      exp_we = (g >= 0);
      exp_reg = '0; exp_data = '0;
      if (g == 2) begin exp_reg = cpu_waddr; exp_data = cpu_wdata; end
      else if (g >= 0) begin exp_reg = ma[g]; exp_data = md[g]; end
      for (int k = 0; k < 2; k++) begin
        if (mv[k] && g != k) mage[k] = (mage[k] < AGE_MAX) ? mage[k] + 1 : AGE_MAX;
        else mage[k] = 0;
        if (g == k) mv[k] = 0;
        if (eack[k] && paddr[k] != 0) begin
          mv[k] = 1; ma[k] = paddr[k]; md[k] = pdata[k]; mage[k] = 0;
        end
      end
      if (g == 0 || g == 1) last_pg = g;
      #1;
      chk($sformatf("rnd%0d_we", cyc), ctrl_writeEnable, exp_we);
      if (exp_we) begin
        chk($sformatf("rnd%0d_wr", cyc), {ctrl_writeReg, data_writeReg}, {exp_reg, exp_data});
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
